// File: rtl/entities_rasterizer_if.sv
// rtl/entities_rasterizer_if.sv - line control, entity RAM read port and pixel path of the rasterizer
// Ports: line_start/line_y/entities_number (line request), address_read_ent/data_read_ent
// (entity RAM), pixel_x/pixel_color (display), busy/line_overrun (status).
interface entities_rasterizer_if;
    logic        line_start;
    logic [8:0]  line_y;
    logic [7:0]  entities_number;
    logic [7:0]  address_read_ent;
    logic [20:0] data_read_ent;
    logic [8:0]  pixel_x;
    logic [2:0]  pixel_color;
    logic        busy;
    logic        line_overrun;

    modport master (
        output line_start, line_y, entities_number, data_read_ent, pixel_x,
        input  address_read_ent, pixel_color, busy, line_overrun
    );

    modport slave (
        input  line_start, line_y, entities_number, data_read_ent, pixel_x,
        output address_read_ent, pixel_color, busy, line_overrun
    );
endinterface

// File: rtl/entities_rasterizer.sv
// rtl/entities_rasterizer.sv - paints 48x48 entity squares into a double-buffered line buffer
// Ports: clk, reset (async, active-high), bus (entities_rasterizer_if.slave): line request in,
// entity RAM address out / data in, pixel_x in / registered pixel_color out, busy and sticky overrun out.
module entities_rasterizer #(
    parameter int         ENT_SIZE = 48,
    parameter int         H_ACTIVE = 480,
    parameter int         V_ACTIVE = 480,
    parameter int         RD_LAT   = 2,
    parameter logic [2:0] BG_CODE  = 3'b000
) (
    input  logic                  clk,
    input  logic                  reset,
    entities_rasterizer_if.slave  bus
);
    localparam int         LY_W      = $clog2(V_ACTIVE);
    localparam logic [9:0] H_END     = 10'(H_ACTIVE);
    localparam logic [8:0] X_END9    = 9'(H_ACTIVE);
    localparam logic [8:0] X_LAST    = 9'(H_ACTIVE - 1);
    localparam logic [9:0] SIZE10    = 10'(ENT_SIZE);
    localparam logic [3:0] WAIT_LAST = 4'(RD_LAT - 2);

    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, WAIT, CHECK, FILL, NEXT, DONE} state_t;

    state_t          state, state_next;
    logic            bank_sel;          // front bank; the back bank is ~bank_sel
    logic [LY_W-1:0] line_y_q;
    logic [7:0]      num_q;
    logic [7:0]      index;
    logic [8:0]      x, x_end;
    logic [2:0]      code_q;
    logic [3:0]      wait_cnt;

    // Both banks in one array, addressed by {bank, column}.
    logic [2:0]      line_mem [0:1023];

    logic            wr_en;
    logic [2:0]      wr_data;

    logic [8:0]      ent_row, ent_col;
    logic [9:0]      row_end, col_end;
    logic            hit;
    logic [8:0]      fill_end;

    // Entity decode is purely unsigned: wrapped coordinates simply fail the compares.
    always_comb begin
        ent_row  = bus.data_read_ent[17:9];
        ent_col  = bus.data_read_ent[8:0];
        row_end  = {1'b0, ent_row} + SIZE10;
        col_end  = {1'b0, ent_col} + SIZE10;
        hit      = (line_y_q >= ent_row) && ({1'b0, line_y_q} < row_end) && ({1'b0, ent_col} < H_END);
        fill_end = (col_end > H_END) ? X_END9 : col_end[8:0];
    end

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_data    = BG_CODE;
        case (state)
            IDLE:  state_next = IDLE;
            CLEAR: begin
                wr_en = 1'b1;
                if (x == X_LAST) state_next = (num_q == 8'd0) ? DONE : FETCH;
            end
            FETCH: state_next = WAIT;
            WAIT:  if (wait_cnt == WAIT_LAST) state_next = CHECK;
            CHECK: state_next = hit ? FILL : NEXT;
            FILL: begin
                wr_en   = 1'b1;
                wr_data = code_q;
                if (x + 9'd1 == x_end) state_next = NEXT;
            end
            NEXT:  state_next = (index == num_q - 8'd1) ? DONE : FETCH;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // A swap takes priority; the pending write would land in the new front bank.
        if (bus.line_start) begin
            state_next = CLEAR;
            wr_en      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) line_mem[{~bank_sel, x}] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            bank_sel             <= 1'b0;
            bus.busy             <= 1'b0;
            bus.line_overrun     <= 1'b0;
            bus.address_read_ent <= 8'd0;
            bus.pixel_color      <= 3'd0;
            line_y_q             <= '0;
            num_q                <= 8'd0;
            index                <= 8'd0;
            x                    <= 9'd0;
            x_end                <= 9'd0;
            code_q               <= 3'd0;
            wait_cnt             <= 4'd0;
        end else begin
            state           <= state_next;
            bus.pixel_color <= (bus.pixel_x >= X_END9) ? BG_CODE : line_mem[{bank_sel, bus.pixel_x}];
            if (bus.line_start) begin
                bank_sel <= ~bank_sel;
                line_y_q <= bus.line_y;
                num_q    <= bus.entities_number;
                index    <= 8'd0;
                x        <= 9'd0;
                bus.busy <= 1'b1;
                if (bus.busy) bus.line_overrun <= 1'b1;
            end else begin
                case (state)
                    CLEAR: begin
                        x <= x + 9'd1;
                        if (x == X_LAST) bus.address_read_ent <= index;
                    end
                    FETCH: wait_cnt <= 4'd0;
                    WAIT:  wait_cnt <= wait_cnt + 4'd1;
                    CHECK: begin
                        code_q <= bus.data_read_ent[20:18];
                        x      <= ent_col;
                        x_end  <= fill_end;
                    end
                    FILL:  x <= x + 9'd1;
                    NEXT: begin
                        if (index != num_q - 8'd1) begin
                            index                <= index + 8'd1;
                            bus.address_read_ent <= index + 8'd1;
                        end
                    end
                    DONE:  bus.busy <= 1'b0;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/entities_rasterizer.md
Name: entities_rasterizer

Overview:
- Downstream consumer of the entity RAM that the entity drawer fills. Each entry is 21 bits: {code[2:0], row[8:0], col[8:0]}, where row and col are the top-left pixel of a 48x48 square.
- For each scanline, the block walks entries 0..entities_number-1 in index order and paints a line buffer. Later entries overwrite earlier ones, so background tiles are painted first and moving entities land on top.
- The line buffer is double-buffered: one line renders in the back bank while the front bank feeds the VGA pixel path with a 3-bit colour code.

Parameters:
- ENT_SIZE, 48, square edge in pixels.
- H_ACTIVE, 480, visible pixels per line; this is also the line-buffer depth.
- V_ACTIVE, 480, visible lines.
- RD_LAT, 2, entity RAM read latency in cycles, counted from address change to data valid.
- BG_CODE, 3'b000, colour code used to clear a line.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- line_start  in  1  one-cycle pulse: swap banks and start rendering line_y.
- line_y  in  9  line to render, sampled on line_start.
- entities_number  in  8  count of valid entity entries, sampled on line_start.
- address_read_ent  out  8  entity RAM read address.
- data_read_ent  in  21  entity RAM read data.
- pixel_x  in  9  display pixel column.
- pixel_color  out  3  colour code for pixel_x, registered.
- busy  out  1  high while rendering.
- line_overrun  out  1  sticky; set when a line_start arrives while busy.

Behaviour:
- Reset (asynchronous) values:
  - FSM goes to IDLE.
  - pixel_color=0, busy=0, line_overrun=0, address_read_ent=0.
  - Bank select = 0.
  - Line-buffer contents are not reset.
- Display path:
  - pixel_color <= front[pixel_x] one cycle after pixel_x is presented.
  - If pixel_x >= H_ACTIVE, pixel_color <= BG_CODE.
- line_start in any state:
  - Toggle bank select (back becomes front).
  - Latch line_y and entities_number.
  - Set entity index=0, set busy=1, and enter CLEAR.
  - If busy was already 1, the abort is immediate and line_overrun is set. The partial line goes to display.
- FSM states:
  - IDLE: wait for line_start.
  - CLEAR: write BG_CODE to back[x] for x=0..H_ACTIVE-1, one per cycle. Afterwards go to FETCH, or to DONE if entities_number==0.
  - FETCH: drive address_read_ent=index, then go to WAIT.
  - WAIT: count RD_LAT-1 further cycles; data_read_ent is sampled in CHECK.
  - CHECK: latch the entry. Compute the 10-bit sums row+ENT_SIZE and col+ENT_SIZE.
    - Hit iff line_y >= row, line_y < row+ENT_SIZE (10-bit compare), and col < H_ACTIVE.
    - Hit: x=col, x_end=min(col+ENT_SIZE, H_ACTIVE), go to FILL.
    - Miss: go to NEXT.
  - FILL: write back[x]=code and increment x each cycle until x==x_end, then go to NEXT.
  - NEXT: if index==entities_number-1, go to DONE; else increment index and go to FETCH.
  - DONE: busy=0, go to IDLE.
- Coordinates are unsigned 9-bit. An entity whose row or col wrapped on subtraction (e.g. 0-5=507) is off-screen and is skipped or clipped purely by these compares. No signed handling.
- Right edge is clipped to H_ACTIVE-1. A line_y >= V_ACTIVE is still rendered; the caller does not request it.
- Write order defines priority: the last-indexed entity covering a pixel wins.
- Front bank is never written; back bank is never read by the display path.
- Worst-case render time is H_ACTIVE + entities_number*(RD_LAT+2) + hits*ENT_SIZE cycles. Exceeding the line period is reported only via line_overrun.

Test Plan:
- Reset mid-FILL → busy=0, pixel_color=0, line_overrun=0 immediately, without waiting for a clk edge.
- entities_number=0, line_start(line_y=10) → after 480 CLEAR cycles busy falls. Next line_start swaps; pixel_x 0..479 all read BG_CODE.
- Entry0={3'b100,row=0,col=96}, n=1, line_y=47 → after the swap, pixel_color=3'b100 for x=96..143 and BG_CODE elsewhere. line_y=48 → no hit.
- Entry0={001,0,0}, entry1={011,10,20}, line_y=20 → x=0..19:001, x=20..67:011, x=68..479:BG.
- Entry col=460, row=0, line_y=0 → x=460..479 painted, no write beyond 479. col=500 → skipped. row=507 (wrapped) → no hit on any line 0..479.
- line_start issued while busy (n=100 with many hits) → line_overrun=1 and stays set, banks swap, a new render starts with index=0.
